// File: rtl/clk_lock_div_mgr_if.sv
// Divider configuration port: write strobe, channel select and value from the
// controller, plus the per-channel pending-update flags back to it.
interface clk_lock_div_mgr_if #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              div_wr_en;
   logic [CH_W-1:0]   div_wr_ch;
   logic [DIV_W-1:0]  div_wr_val;
   logic [NUM_CH-1:0] div_busy;

   modport master (output div_wr_en, div_wr_ch, div_wr_val, input div_busy);
   modport slave  (input div_wr_en, div_wr_ch, div_wr_val, output div_busy);
endinterface

// File: rtl/clk_lock_div_mgr.sv
// PLL lock qualifier, downstream reset/ready generator and programmable
// clock-enable dividers with glitch-free updates at terminal count.
//
//  state     | meaning
//  WAIT_LOCK | waiting for synchronised lock, downstream held in reset
//  HOLD      | debouncing lock for LOCK_HOLD consecutive cycles
//  RST_HOLD  | lock qualified, stretching rst_out for RST_EXTRA cycles
//  RUN       | ready, dividers running; lock loss is counted
module clk_lock_div_mgr #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 3,
   parameter int LOCK_HOLD   = 1024,
   parameter int RST_EXTRA   = 16,
   parameter int LOSS_W      = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pll_lock,
   clk_lock_div_mgr_if.slave   cfg,
   input  logic                loss_clr,
   output logic                ready,
   output logic                rst_out,
   output logic [NUM_CH-1:0]   ce,
   output logic [NUM_CH-1:0]   sclk,
   output logic [LOSS_W-1:0]   loss_cnt
);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
   localparam int EXT_W  = (RST_EXTRA > 1) ? $clog2(RST_EXTRA) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LOCK_HOLD - 1);
   localparam logic [EXT_W-1:0]  EXT_LOAD  = EXT_W'(RST_EXTRA - 1);
   localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DIV_DEFAULT);

   typedef enum logic [1:0] {WAIT_LOCK, HOLD, RST_HOLD, RUN} state_t;

   state_t            state, state_n;
   logic              sync1, lock_s;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
   logic [EXT_W-1:0]  ext_cnt, ext_cnt_n;
   logic              loss_evt;
   logic              run_stay;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WAIT_LOCK;
         sync1    <= 1'b0;
         lock_s   <= 1'b0;
         hold_cnt <= '0;
         ext_cnt  <= '0;
         ready    <= 1'b0;
         rst_out  <= 1'b1;
      end else begin
         sync1    <= pll_lock;
         lock_s   <= sync1;
         state    <= state_n;
         hold_cnt <= hold_cnt_n;
         ext_cnt  <= ext_cnt_n;
         ready    <= (state_n == RUN);
         rst_out  <= (state_n != RUN);
      end
   end

   // Hold and stretch timers count down and terminate at zero.
   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      ext_cnt_n  = ext_cnt;
      loss_evt   = 1'b0;
      case (state)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n    = HOLD;
               hold_cnt_n = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
            end else if (hold_cnt == '0) begin
               state_n   = RST_HOLD;
               ext_cnt_n = EXT_LOAD;
            end else begin
               hold_cnt_n = hold_cnt - 1'b1;
            end
         end
         RST_HOLD: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
            end else if (ext_cnt == '0) begin
               state_n = RUN;
            end else begin
               ext_cnt_n = ext_cnt - 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_n  = WAIT_LOCK;
               loss_evt = 1'b1;
            end
         end
         default: state_n = WAIT_LOCK;
      endcase
      // Channels only count while RUN persists, so they clear on the same
      // edge that drops ready and start fresh on the edge after entry.
      run_stay = (state == RUN) && (state_n == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         loss_cnt <= '0;
      end else if (loss_clr) begin
         loss_cnt <= loss_evt ? LOSS_W'(1) : '0;
      end else if (loss_evt && !(&loss_cnt)) begin
         loss_cnt <= loss_cnt + 1'b1;
      end
   end

   logic [DIV_W-1:0]  div_q  [NUM_CH];
   logic [DIV_W-1:0]  shadow [NUM_CH];
   logic [DIV_W-1:0]  cnt    [NUM_CH];
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] wr_sel;
   logic              wr_ok;

   always_comb begin
      wr_ok  = cfg.div_wr_en && (32'(cfg.div_wr_ch) < 32'(NUM_CH));
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i] = wr_ok && (cfg.div_wr_ch == CH_W'(i));
      end
   end

   // A write on the same edge as an apply lands in shadow after the old
   // pending value has moved to div, so it waits for the next terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]  <= DIV_RST;
            shadow[i] <= DIV_RST;
            cnt[i]    <= '0;
         end
         ce   <= '0;
         sclk <= '0;
         busy <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (run_stay) begin
               if (cnt[i] == div_q[i]) begin
                  cnt[i]  <= '0;
                  ce[i]   <= 1'b1;
                  sclk[i] <= ~sclk[i];
                  if (busy[i]) begin
                     div_q[i] <= shadow[i];
                     busy[i]  <= 1'b0;
                  end
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
                  ce[i]  <= 1'b0;
               end
            end else begin
               cnt[i]  <= '0;
               ce[i]   <= 1'b0;
               sclk[i] <= 1'b0;
               if (busy[i]) begin
                  div_q[i] <= shadow[i];
                  busy[i]  <= 1'b0;
               end
            end
            if (wr_sel[i]) begin
               shadow[i] <= cfg.div_wr_val;
               busy[i]   <= 1'b1;
            end
         end
      end
   end

   assign cfg.div_busy = busy;
endmodule

// File: doc/clk_lock_div_mgr.md
Name: clk_lock_div_mgr

Overview:
- Runs in the PLL output clock domain; sits directly after the SPI/system PLL wrapper.
- Qualifies the raw PLL lock (synchronise, debounce, extra reset stretch), then generates a clean synchronous downstream reset and a ready flag.
- Generates NUM_CH runtime-programmable clock-enable / SCK-style divided outputs with glitch-free divider updates.
- Counts lock-loss events for debug.

Parameters:
NUM_CH, 2, number of divider channels (1..8)
DIV_W, 8, divider register width per channel
DIV_DEFAULT, 3, divider value loaded into every channel on rst
LOCK_HOLD, 1024, consecutive synchronised-lock cycles required before reset stretch (>=1)
RST_EXTRA, 16, cycles rst_out stays high after lock is qualified (>=1)
LOSS_W, 4, width of saturating lock-loss counter
CH_W, max(1,clog2(NUM_CH)), derived, channel index width

Ports:
clk  in  1  PLL output clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pll_lock  in  1  raw PLL lock; asynchronous
div_wr_en  in  1  divider write strobe, single cycle
div_wr_ch  in  CH_W  target channel
div_wr_val  in  DIV_W  new divider value
loss_clr  in  1  clears loss_cnt
ready  out  1  clocks qualified, channels running
rst_out  out  1  synchronous active-high reset for downstream logic
ce  out  NUM_CH  one-cycle enable pulse per channel
sclk  out  NUM_CH  50% divided clock per channel (data signal, not a clock net)
div_busy  out  NUM_CH  channel has a pending divider update
loss_cnt  out  LOSS_W  saturating count of lock losses while in RUN

Behaviour:
- Reset values:
  - state=WAIT_LOCK, ready=0, rst_out=1, ce=0, sclk=0, div_busy=0, loss_cnt=0.
  - All div=shadow=DIV_DEFAULT; all counters 0; sync flops 0.
- Lock synchroniser: 2-FF synchroniser produces lock_s; 2 cycles latency.
- FSM, all outputs registered:
  - WAIT_LOCK: lock_s=1 -> HOLD, hold_cnt=0.
  - HOLD: lock_s=0 -> WAIT_LOCK (not a loss). Otherwise, if hold_cnt==LOCK_HOLD-1 -> RST_HOLD with ext_cnt=0; else hold_cnt++. Total: exactly LOCK_HOLD edges in HOLD.
  - RST_HOLD: lock_s=0 -> WAIT_LOCK. Otherwise, if ext_cnt==RST_EXTRA-1 -> RUN; else ext_cnt++. On the RUN transition, ready<=1 and rst_out<=0 on the same edge.
  - RUN: lock_s=0 -> WAIT_LOCK; ready<=0, rst_out<=1 on the same edge; loss_cnt increments, saturating at all-ones.
  - Resulting latency: ready rises on edge 2+LOCK_HOLD+RST_EXTRA, counting from edge 0 = first edge sampling pll_lock=1.
- loss_cnt:
  - loss_clr alone -> 0.
  - loss_clr on the same edge as a loss event -> 1.
- Channel divider, only in RUN:
  - cnt counts 0..div. At cnt==div: cnt<=0, ce<=1 for one cycle, sclk toggles. Otherwise ce<=0.
  - ce period = div+1 cycles; sclk period = 2*(div+1).
  - First ce is high in cycle div+1 after RUN entry.
  - div=0: ce continuously high; sclk toggles every cycle.
- Outside RUN: cnt=0, ce=0, sclk=0. div/shadow registers are retained.
- Divider update:
  - div_wr_en with div_wr_ch<NUM_CH: shadow[ch]<=div_wr_val, div_busy[ch]<=1.
  - div_wr_ch>=NUM_CH: write ignored.
  - In RUN, pending shadow copies to div at that channel's next terminal count (cnt==div) and div_busy clears. The terminal cycle still uses the old div.
  - Write landing on a terminal-count edge: stored in shadow, div_busy stays 1; applied at the following terminal count.
  - Write while busy: overwrites shadow.
  - Outside RUN: shadow->div applied on the next edge; div_busy pulses for 1 cycle.
- rst asserted mid-operation: everything returns to reset values on the next edge, including loss_cnt and div=DIV_DEFAULT.
- pll_lock glitch shorter than 1 cycle may be missed; no requirement to catch it.

Test Plan:
1. LOCK_HOLD=8, RST_EXTRA=4; rst released, pll_lock=1 from edge 0 -> ready=1 and rst_out=0 after edge 14, not earlier; loss_cnt=0.
2. In HOLD, pll_lock low for 3 cycles then high -> FSM back to WAIT_LOCK; ready delayed by full restart (14 edges from re-rise); loss_cnt stays 0.
3. RUN, DIV_DEFAULT=3 -> ce[0] one-cycle pulse every 4 cycles, first pulse 4 cycles after RUN entry; sclk[0] period 8, duty 4/4; div_busy=0.
4. RUN, ch0 div=3; write val=1 at cnt=1 -> div_busy[0]=1 until cnt==3 terminal; ce[0] spacing then becomes 2; no short/long sclk half-period other than the old-length one; ch1 unaffected.
5. RUN, drop pll_lock -> ready=0, rst_out=1, ce=0, sclk=0 on edge 3 after drop; loss_cnt=1. With LOSS_W=2, repeat 4 losses -> loss_cnt=3 (saturated). loss_clr coincident with a loss -> 1.
6. Write div=0 to ch1 -> ce[1] constantly high, sclk[1] toggles each cycle. Write ch index 2 with NUM_CH=2 -> no register or div_busy change.
